// File: rtl/wb_stage_pipelined.sv
// -----------------------------------------------------------------------------
// wb_stage_pipelined
//
// Registered write-back stage between the data-memory stage and the register
// file. It chooses the write-back source (load data, ALU result or PC+4),
// aligns and extends load data by byte offset and access size, flags misaligned
// loads, suppresses writes to x0 and to the reserved source, and counts retired
// instructions. Every output is registered, one cycle after its inputs.
//
// Parameters
//   XLEN   datapath width (32 or 64; load alignment is defined for 32)
//   RA_W   register-address width
//   CNT_W  retired-instruction counter width
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   stall          in   hold every stage register, including the counter
//   flush          in   load a bubble (counter held)
//   in_valid       in   incoming instruction is real
//   in_pc          in   PC of incoming instruction
//   in_alu_res     in   ALU result; bits [1:0] are the load byte offset
//   in_dmem_data   in   raw aligned word from data memory
//   in_funct3      in   load size / sign field
//   in_wb_sel      in   00 DMEM, 01 ALU, 10 PC+4, 11 reserved
//   in_rd          in   destination register
//   in_reg_wen     in   instruction writes rd
//   wb_valid       out  registered instruction retires this cycle
//   wb_wen         out  register-file write enable
//   wb_rd          out  register-file write address
//   wb_data        out  register-file write data
//   wb_misaligned  out  retiring load was misaligned
//   retired        out  retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module wb_stage_pipelined #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_alu_res,
  input  logic [XLEN-1:0]  in_dmem_data,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_wb_sel,
  input  logic [RA_W-1:0]  in_rd,
  input  logic             in_reg_wen,
  output logic             wb_valid,
  output logic             wb_wen,
  output logic [RA_W-1:0]  wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_misaligned,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SEL_DMEM = 2'b00;
  localparam logic [1:0] SEL_ALU  = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_RSVD = 2'b11;

  // Shift the memory word down by the byte offset, then extend the selected
  // byte or halfword. Word loads and unknown funct3 pass the raw word through.
  function automatic logic [XLEN-1:0] load_align(
    input logic [XLEN-1:0] data,
    input logic [1:0]      off,
    input logic [2:0]      f3
  );
    logic [XLEN-1:0] sh;
    logic signed [7:0]  s8;
    logic signed [15:0] s16;
    sh  = data >> {off, 3'b000};
    s8  = sh[7:0];
    s16 = sh[15:0];
    case (f3)
      F3_LB:   load_align = {{(XLEN-8){s8[7]}}, s8};
      F3_LBU:  load_align = {{(XLEN-8){1'b0}}, sh[7:0]};
      F3_LH:   load_align = {{(XLEN-16){s16[15]}}, s16};
      F3_LHU:  load_align = {{(XLEN-16){1'b0}}, sh[15:0]};
      default: load_align = data;
    endcase
  endfunction

  // A halfword at offset 3 would straddle the word; a word must be at offset 0.
  function automatic logic load_misaligned(
    input logic [1:0] off,
    input logic [2:0] f3
  );
    case (f3)
      F3_LH, F3_LHU: load_misaligned = (off == 2'd3);
      F3_LW:         load_misaligned = (off != 2'd0);
      default:       load_misaligned = 1'b0;
    endcase
  endfunction

  logic [1:0]      w_off;
  logic [XLEN-1:0] w_load_data;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_src_data;
  logic            w_misaligned;
  logic            w_wen;

  assign w_off       = in_alu_res[1:0];
  assign w_load_data = load_align(in_dmem_data, w_off, in_funct3);
  assign w_pc_plus4  = in_pc + XLEN'(4);

  always_comb begin
    w_src_data = '0;
    case (in_wb_sel)
      SEL_DMEM: w_src_data = w_load_data;
      SEL_ALU:  w_src_data = in_alu_res;
      SEL_PC4:  w_src_data = w_pc_plus4;
      SEL_RSVD: w_src_data = '0;
      default:  w_src_data = '0;
    endcase
  end

  // Misalignment is only meaningful for a real instruction taking load data;
  // bubbles never raise it.
  assign w_misaligned = in_valid & (in_wb_sel == SEL_DMEM)
                      & load_misaligned(w_off, in_funct3);

  assign w_wen = in_valid & in_reg_wen & (in_rd != '0)
               & (in_wb_sel != SEL_RSVD) & ~w_misaligned;

  logic             r_vld_p1;
  logic             r_wen_p1;
  logic [RA_W-1:0]  r_rd_p1;
  logic [XLEN-1:0]  r_data_p1;
  logic             r_mis_p1;
  logic [CNT_W-1:0] r_retired_p1;

  // ---- stage boundary: inputs -> write-back registers (reset > flush > stall > load)
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld_p1     <= 1'b0;
      r_wen_p1     <= 1'b0;
      r_rd_p1      <= '0;
      r_data_p1    <= '0;
      r_mis_p1     <= 1'b0;
      r_retired_p1 <= '0;
    end else if (flush) begin
      r_vld_p1     <= 1'b0;
      r_wen_p1     <= 1'b0;
      r_rd_p1      <= '0;
      r_data_p1    <= '0;
      r_mis_p1     <= 1'b0;
    end else if (!stall) begin
      r_vld_p1     <= in_valid;
      r_wen_p1     <= w_wen;
      r_rd_p1      <= in_rd;
      r_data_p1    <= w_src_data;
      r_mis_p1     <= w_misaligned;
      if (in_valid) begin
        r_retired_p1 <= r_retired_p1 + CNT_W'(1);
      end
    end
  end

  assign wb_valid      = r_vld_p1;
  assign wb_wen        = r_wen_p1;
  assign wb_rd         = r_rd_p1;
  assign wb_data       = r_data_p1;
  assign wb_misaligned = r_mis_p1;
  assign retired       = r_retired_p1;

endmodule

// File: tb/tb_wb_stage_pipelined.sv
module tb_wb_stage_pipelined;

  logic        clock = 1'b0;
  logic        reset, stall, flush, in_valid, in_reg_wen;
  logic [31:0] in_pc, in_alu_res, in_dmem_data;
  logic [2:0]  in_funct3;
  logic [1:0]  in_wb_sel;
  logic [4:0]  in_rd;

  logic        wb_valid, wb_wen, wb_misaligned;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [63:0] retired;

  logic        c_valid, c_wen, c_mis;
  logic [4:0]  c_rd;
  logic [31:0] c_data;
  logic [3:0]  c_retired;

  int checks = 0;
  int errors = 0;

  // Reference state, expressed as the architectural outputs.
  bit        m_valid, m_wen, m_mis, m_known;
  bit [4:0]  m_rd;
  bit [31:0] m_data;
  bit [63:0] m_ret;

  always #5 clock = ~clock;

  wb_stage_pipelined #(.XLEN(32), .RA_W(5), .CNT_W(64)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_alu_res(in_alu_res),
    .in_dmem_data(in_dmem_data), .in_funct3(in_funct3), .in_wb_sel(in_wb_sel),
    .in_rd(in_rd), .in_reg_wen(in_reg_wen),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_misaligned(wb_misaligned), .retired(retired)
  );

  // Narrow-counter copy sharing the same stimulus, for wrap checking.
  wb_stage_pipelined #(.XLEN(32), .RA_W(5), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_alu_res(in_alu_res),
    .in_dmem_data(in_dmem_data), .in_funct3(in_funct3), .in_wb_sel(in_wb_sel),
    .in_rd(in_rd), .in_reg_wen(in_reg_wen),
    .wb_valid(c_valid), .wb_wen(c_wen), .wb_rd(c_rd), .wb_data(c_data),
    .wb_misaligned(c_mis), .retired(c_retired)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_mis(bit [2:0] f3, bit [1:0] off);
    if ((f3 == 3'd1 || f3 == 3'd5) && off == 2'd3) return 1'b1;
    if (f3 == 3'd2 && off != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  // Write-back value from the spec rules, using plain arithmetic.
  function automatic bit [31:0] ref_data(bit [1:0] sel, bit [31:0] pc, bit [31:0] alu,
                                         bit [31:0] dm, bit [2:0] f3);
    int unsigned off, b, h;
    if (sel == 2'd1) return alu;
    if (sel == 2'd2) return pc + 32'd4;
    if (sel == 2'd3) return 32'd0;
    off = alu % 4;
    b = (dm / (32'd1 << (8 * off))) % 256;
    h = (dm / (32'd1 << (8 * off))) % 65536;
    case (f3)
      3'd0: return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd4: return b;
      3'd1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd5: return h;
      default: return dm;
    endcase
  endfunction

  task automatic check_all();
    chk("valid", {63'd0, wb_valid}, {63'd0, m_valid});
    chk("wen", {63'd0, wb_wen}, {63'd0, m_wen});
    chk("misaligned", {63'd0, wb_misaligned}, {63'd0, m_mis});
    chk("retired", retired, m_ret);
    chk("retired4", {60'd0, c_retired}, {60'd0, m_ret[3:0]});
    if (m_known) begin
      chk("rd", {59'd0, wb_rd}, {59'd0, m_rd});
      chk("data", {32'd0, wb_data}, {32'd0, m_data});
    end
  endtask

  // Advance one clock: update the reference from the current inputs, then
  // compare the outputs 1 time unit after the edge.
  task automatic tick();
    bit mis;
    if (reset) begin
      m_valid = 0; m_wen = 0; m_mis = 0; m_rd = 0; m_data = 0; m_ret = 0; m_known = 1;
    end else if (flush) begin
      m_valid = 0; m_wen = 0; m_mis = 0; m_rd = 0; m_data = 0; m_known = 1;
    end else if (!stall) begin
      mis = in_valid && in_wb_sel == 2'd0 && ref_mis(in_funct3, in_alu_res[1:0]);
      m_valid = in_valid;
      m_mis = mis;
      m_wen = in_valid && in_reg_wen && in_rd != 0 && in_wb_sel != 2'd3 && !mis;
      m_rd = in_rd;
      m_data = ref_data(in_wb_sel, in_pc, in_alu_res, in_dmem_data, in_funct3);
      m_known = in_valid;
      if (in_valid) m_ret = m_ret + 1;
    end
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic randomize_inputs();
    in_valid = 1'($urandom);
    in_pc = $urandom;
    in_alu_res = $urandom;
    in_dmem_data = $urandom;
    in_funct3 = 3'($urandom);
    in_wb_sel = 2'($urandom);
    in_rd = 5'($urandom);
    in_reg_wen = 1'($urandom);
  endtask

  task automatic op(input bit [1:0] sel, input bit [2:0] f3, input bit [4:0] rd,
                    input bit [31:0] pc, input bit [31:0] alu, input bit [31:0] dm);
    reset = 0; stall = 0; flush = 0;
    in_valid = 1; in_reg_wen = 1;
    in_wb_sel = sel; in_funct3 = f3; in_rd = rd;
    in_pc = pc; in_alu_res = alu; in_dmem_data = dm;
    tick();
  endtask

  logic [63:0] ret_snap;
  logic [31:0] data_snap;
  logic        wen_snap;
  logic [31:0] base;

  initial begin
    m_valid = 0; m_wen = 0; m_mis = 0; m_rd = 0; m_data = 0; m_ret = 0; m_known = 0;
    reset = 1; stall = 0; flush = 0;
    randomize_inputs();

    // Reset held for two cycles with random inputs.
    tick();
    randomize_inputs();
    stall = 1'($urandom); flush = 1'($urandom);
    tick();
    chk("reset_valid", {63'd0, wb_valid}, 64'd0);
    chk("reset_data", {32'd0, wb_data}, 64'd0);
    chk("reset_retired", retired, 64'd0);

    // Three valid ALU ops.
    for (int i = 0; i < 3; i++) op(2'd1, 3'($urandom), 5'd1 + 5'(i), $urandom, $urandom, $urandom);
    chk("three_ops_retired", retired, 64'd3);

    // Load alignment on a fixed memory word.
    base = $urandom & 32'hFFFFFFFC;
    op(2'd0, 3'd0, 5'd5, $urandom, base | 32'd0, 32'h8899AABB);
    chk("lb_off0", {32'd0, wb_data}, 64'hFFFFFFBB);
    chk("lb_wen", {63'd0, wb_wen}, 64'd1);
    op(2'd0, 3'd4, 5'd5, $urandom, base | 32'd1, 32'h8899AABB);
    chk("lbu_off1", {32'd0, wb_data}, 64'h000000AA);
    op(2'd0, 3'd1, 5'd5, $urandom, base | 32'd2, 32'h8899AABB);
    chk("lh_off2", {32'd0, wb_data}, 64'hFFFF8899);
    op(2'd0, 3'd5, 5'd5, $urandom, base | 32'd0, 32'h8899AABB);
    chk("lhu_off0", {32'd0, wb_data}, 64'h0000AABB);
    op(2'd0, 3'd2, 5'd5, $urandom, base | 32'd0, 32'h8899AABB);
    chk("lw_off0", {32'd0, wb_data}, 64'h8899AABB);
    chk("lw_wen", {63'd0, wb_wen}, 64'd1);
    chk("lw_rd", {59'd0, wb_rd}, 64'd5);

    // Misaligned loads and x0.
    op(2'd0, 3'd2, 5'd5, $urandom, base | 32'd2, 32'h8899AABB);
    chk("lw_off2_mis", {63'd0, wb_misaligned}, 64'd1);
    chk("lw_off2_wen", {63'd0, wb_wen}, 64'd0);
    op(2'd0, 3'd1, 5'd7, $urandom, base | 32'd3, $urandom);
    chk("lh_off3_mis", {63'd0, wb_misaligned}, 64'd1);
    chk("lh_off3_wen", {63'd0, wb_wen}, 64'd0);
    ret_snap = retired;
    op(2'd1, 3'd0, 5'd0, $urandom, $urandom, $urandom);
    chk("x0_wen", {63'd0, wb_wen}, 64'd0);
    chk("x0_valid", {63'd0, wb_valid}, 64'd1);
    chk("x0_retired", retired, ret_snap + 64'd1);

    // Select paths.
    op(2'd2, 3'd0, 5'd9, 32'h00000100, $urandom, $urandom);
    chk("pc4", {32'd0, wb_data}, 64'h00000104);
    op(2'd2, 3'd0, 5'd9, 32'hFFFFFFFC, $urandom, $urandom);
    chk("pc4_wrap", {32'd0, wb_data}, 64'h00000000);
    op(2'd3, 3'd0, 5'd9, $urandom, $urandom, $urandom);
    chk("rsvd_data", {32'd0, wb_data}, 64'd0);
    chk("rsvd_wen", {63'd0, wb_wen}, 64'd0);

    // Stall for three cycles with changing inputs.
    op(2'd1, 3'd0, 5'd11, $urandom, 32'h13572468, $urandom);
    ret_snap = retired; data_snap = wb_data; wen_snap = wb_wen;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      in_valid = 1;
      stall = 1;
      tick();
      chk("stall_data", {32'd0, wb_data}, {32'd0, data_snap});
      chk("stall_retired", retired, ret_snap);
      chk("stall_wen", {63'd0, wb_wen}, {63'd0, wen_snap});
    end
    // Flush beats stall.
    randomize_inputs();
    in_valid = 1; stall = 1; flush = 1;
    tick();
    chk("flush_valid", {63'd0, wb_valid}, 64'd0);
    chk("flush_wen", {63'd0, wb_wen}, 64'd0);
    chk("flush_retired", retired, ret_snap);
    // Next unstalled op is captured normally.
    op(2'd1, 3'd0, 5'd12, $urandom, 32'hCAFEF00D, $urandom);
    chk("after_flush_data", {32'd0, wb_data}, 64'hCAFEF00D);
    chk("after_flush_retired", retired, ret_snap + 64'd1);

    // Counter wrap on the 4-bit instance.
    reset = 1; tick();
    for (int i = 0; i < 17; i++) op(2'd1, 3'd0, 5'($urandom), $urandom, $urandom, $urandom);
    chk("wrap_retired4", {60'd0, c_retired}, 64'd1);
    chk("wrap_retired64", retired, 64'd17);

    // Randomized traffic with occasional stall, flush and reset.
    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      reset = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_stage_pipelined.md
# wb_stage_pipelined

Registered, parametrised write-back stage that sits between the data-memory stage and the register file. It selects the write-back source, aligns and sign/zero-extends load data by byte offset and access size, and forms the link value for jumps. It also suppresses writes to x0 and illegal cases, supports pipeline stall and flush, and keeps a retired-instruction counter. All outputs are registered, with one cycle of latency from the inputs.

## Interface
- XLEN, 32: datapath width; legal values 32 and 64. Load alignment below is specified for XLEN=32.
- RA_W, 5: register-address width.
- CNT_W, 64: retired-instruction counter width.

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold all stage registers.
- flush  in  1  insert a bubble.
- in_valid  in  1  the incoming instruction is real.
- in_pc  in  XLEN  PC of the incoming instruction.
- in_alu_res  in  XLEN  ALU result; its low 2 bits are also the load byte offset.
- in_dmem_data  in  XLEN  raw aligned word from data memory.
- in_funct3  in  3  load size and sign field.
- in_wb_sel  in  2  source select: 00 DMEM, 01 ALU, 10 PC+4, 11 reserved.
- in_rd  in  RA_W  destination register.
- in_reg_wen  in  1  the instruction writes rd.
- wb_valid  out  1  a registered instruction is retiring this cycle.
- wb_wen  out  1  register-file write enable.
- wb_rd  out  RA_W  register-file write address.
- wb_data  out  XLEN  register-file write data.
- wb_misaligned  out  1  the retiring load was misaligned.
- retired  out  CNT_W  count of retired instructions.

## Operation
- **Source select (combinational on inputs, then registered):**
  - 00: aligned load data.
  - 01: in_alu_res.
  - 10: in_pc + 4, truncated to XLEN.
  - 11: data 0, and the write is suppressed.
- **Load alignment:** off = in_alu_res[1:0]; sh = in_dmem_data >> (8*off).
  - funct3 000 (LB): sign-extend sh[7:0].
  - funct3 100 (LBU): zero-extend sh[7:0].
  - funct3 001 (LH): sign-extend sh[15:0].
  - funct3 101 (LHU): zero-extend sh[15:0].
  - funct3 010 (LW): in_dmem_data.
  - Any other funct3: in_dmem_data, no flag.
- **Misaligned:** applies only when wb_sel=00.
  - Raised for LH/LHU with off=3, or LW with off≠0.
  - wb_misaligned=1, wb_wen=0, wb_data still holds the computed value.
- **Write enable:** wb_wen = in_valid & in_reg_wen & (in_rd≠0) & (wb_sel≠11) & ~misaligned, all evaluated at capture.
- **Counter:** retired increments by 1 on every edge where the register loads with in_valid=1 (not stalled, not flushed, not in reset). It wraps modulo 2^CNT_W.
- **Priority on each rising edge:** reset > flush > stall > load.
  - **Reset:** all outputs 0, including retired.
  - **Flush:** wb_valid, wb_wen and wb_misaligned go to 0; wb_rd and wb_data go to 0; retired is held.
  - **Stall:** every output register, including retired, holds its value.
  - **Load:** capture the computed values; wb_valid = in_valid.
- **Bubbles:** when in_valid=0 at load, wb_valid=0, wb_wen=0 and wb_misaligned=0. wb_rd and wb_data are still captured; they are don't-care.

## Timing
- Latency is 1 cycle: inputs present before edge N appear on the outputs after edge N.
- Throughput is 1 instruction per cycle when stall=0.
- While stall=1, the outputs are stable and wb_wen stays at its held value. The register-file write therefore repeats the same (rd, data), which is harmless and idempotent.
- flush and stall asserted together: flush wins; the output becomes a bubble and retired is held.
- Reset asserted mid-stream: the next edge clears everything; the in-flight instruction is lost and not counted.
- Reset values: wb_valid=0, wb_wen=0, wb_rd=0, wb_data=0, wb_misaligned=0, retired=0.

## Test plan
1. **Reset:** hold reset 2 cycles with random inputs → every output is 0 and retired=0. Release reset, then drive 3 valid ALU ops → retired=3.
2. **Load alignment:** in_dmem_data=0x8899AABB.
   - LB off=0 → 0xFFFFFFBB.
   - LBU off=1 → 0x000000AA.
   - LH off=2 → 0xFFFF8899.
   - LHU off=0 → 0x0000AABB.
   - LW off=0 → 0x8899AABB.
   - In every case wb_wen=1 for rd=5.
3. **Misaligned and x0:**
   - LW off=2 → wb_misaligned=1, wb_wen=0.
   - LH off=3 → wb_misaligned=1, wb_wen=0.
   - ALU write with rd=0 → wb_wen=0, wb_valid=1, retired increments.
4. **Select paths:**
   - wb_sel=10, pc=0x00000100 → wb_data=0x00000104.
   - wb_sel=10, pc=0xFFFFFFFC → wb_data=0x00000000.
   - wb_sel=11 → wb_data=0, wb_wen=0.
5. **Stall and flush:**
   - Stall for 3 cycles with changing inputs → outputs and retired are frozen.
   - flush=1 together with stall=1 → wb_valid=0, wb_wen=0, retired unchanged.
   - The next unstalled valid op is captured normally.
6. **Counter wrap:** CNT_W=4, drive 17 valid ops → retired=1.
